// File: rtl/micro_udp_engine_pkg.sv
// -----------------------------------------------------------------------------
// micro_udp_engine_pkg
// Shared types and constants for the micro UDP engine. This slice holds the
// ARP packet layout, the ARP field constants and the transmit FSM states.
// -----------------------------------------------------------------------------
package micro_udp_engine_pkg;

    localparam logic [15:0] ARP_HTYPE_ETH     = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4    = 16'h0800;
    localparam logic [15:0] ARP_OPER_REQUEST  = 16'd1;
    localparam logic [15:0] ARP_OPER_REPLY    = 16'd2;
    localparam int          ARP_PAD_LEN_BYTES = 46;
    localparam int          ARP_BEAT_BYTES    = 32;

    // ARP body as it appears on the wire, first field in the MSBs (224 bits)
    typedef struct packed {
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [7:0]  plen;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } arp_pkt_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1,
        S_GAP
    } arp_tx_state_t;

    // Fill an ARP body from a descriptor; a request carries an all-zero THA
    function automatic arp_pkt_t build_arp_pkt(
        input logic        is_reply,
        input logic [47:0] target_mac,
        input logic [31:0] target_ip,
        input logic [47:0] own_mac,
        input logic [31:0] own_ip
    );
        arp_pkt_t pkt;
        pkt.htype = ARP_HTYPE_ETH;
        pkt.ptype = ARP_PTYPE_IPV4;
        pkt.hlen  = 8'd6;
        pkt.plen  = 8'd4;
        pkt.oper  = is_reply ? ARP_OPER_REPLY : ARP_OPER_REQUEST;
        pkt.sha   = own_mac;
        pkt.spa   = own_ip;
        pkt.tha   = is_reply ? target_mac : 48'h0;
        pkt.tpa   = target_ip;
        return pkt;
    endfunction

endpackage

// File: rtl/micro_udp_engine_arp_tx_if.sv
// -----------------------------------------------------------------------------
// micro_udp_engine_arp_tx_if
// 256-bit Avalon-ST packet bus carrying ARP packets to the Ethernet TX stage.
//   data          : packet data, first byte on [255:248]
//   empty         : unused bytes in the last beat, meaningful only on EOP
//   startofpacket : first beat of a packet
//   endofpacket   : last beat of a packet
//   valid         : source has a beat
//   ready         : sink accepts the beat
// master = source side, slave = sink side.
// -----------------------------------------------------------------------------
interface micro_udp_engine_arp_tx_if;
    logic [255:0] data;
    logic [4:0]   empty;
    logic         startofpacket;
    logic         endofpacket;
    logic         valid;
    logic         ready;

    modport master (
        output data, empty, startofpacket, endofpacket, valid,
        input  ready
    );

    modport slave (
        input  data, empty, startofpacket, endofpacket, valid,
        output ready
    );
endinterface

// File: rtl/micro_udp_engine_arp_tx.sv
// -----------------------------------------------------------------------------
// micro_udp_engine_arp_tx
// Builds ARP request/reply packets from a descriptor and streams each one as a
// two-beat Avalon-ST packet (28-byte ARP body zero-padded to 46 bytes). After
// every packet a programmable idle gap throttles the ARP transmit rate.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   arp_req_valid/ready : descriptor handshake (ready only while idle)
//   arp_req_is_reply    : 1 = reply (OPER 2), 0 = request (OPER 1)
//   arp_req_target_mac  : THA, ignored for a request
//   arp_req_target_ip   : TPA
//   arp_tx              : Avalon-ST source (master modport)
//   tx_pkt_cnt          : completed packet count, wraps at 2^32
// -----------------------------------------------------------------------------
module micro_udp_engine_arp_tx
    import micro_udp_engine_pkg::*;
#(
    parameter logic [47:0] CONFIG_MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter logic [31:0] CONFIG_IP_ADDR  = 32'hC0_A8_00_01,
    parameter int unsigned MIN_GAP_CYCLES  = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              arp_req_valid,
    output logic                              arp_req_ready,
    input  logic                              arp_req_is_reply,
    input  logic [47:0]                       arp_req_target_mac,
    input  logic [31:0]                       arp_req_target_ip,
    micro_udp_engine_arp_tx_if.master         arp_tx,
    output logic [31:0]                       tx_pkt_cnt
);

    localparam logic [15:0] GAP_LOAD   = 16'(MIN_GAP_CYCLES);
    localparam logic [4:0]  LAST_EMPTY = 5'(2 * ARP_BEAT_BYTES - ARP_PAD_LEN_BYTES);

    arp_tx_state_t state, state_next;
    logic [15:0]   gap_cnt, gap_next;
    logic [31:0]   cnt_next;
    logic [255:0]  data_next;
    logic [4:0]    empty_next;
    logic          sop_next, eop_next, valid_next;

    assign arp_req_ready = (state == S_IDLE);

    // Next-state and next-output logic. Every output register holds its value
    // unless a handshake moves the packet forward, which keeps the bus stable
    // under backpressure. The descriptor lives only in the beat-0 data register,
    // so later changes on the request inputs cannot reach the packet.
    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        cnt_next   = tx_pkt_cnt;
        data_next  = arp_tx.data;
        empty_next = arp_tx.empty;
        sop_next   = arp_tx.startofpacket;
        eop_next   = arp_tx.endofpacket;
        valid_next = arp_tx.valid;
        case (state)
            S_IDLE: begin
                if (arp_req_valid) begin
                    data_next  = {build_arp_pkt(arp_req_is_reply, arp_req_target_mac,
                                                arp_req_target_ip, CONFIG_MAC_ADDR,
                                                CONFIG_IP_ADDR), 32'h0};
                    empty_next = 5'd0;
                    sop_next   = 1'b1;
                    eop_next   = 1'b0;
                    valid_next = 1'b1;
                    state_next = S_BEAT0;
                end
            end
            S_BEAT0: begin
                if (arp_tx.ready) begin
                    data_next  = '0;
                    empty_next = LAST_EMPTY;
                    sop_next   = 1'b0;
                    eop_next   = 1'b1;
                    state_next = S_BEAT1;
                end
            end
            S_BEAT1: begin
                if (arp_tx.ready) begin
                    empty_next = 5'd0;
                    eop_next   = 1'b0;
                    valid_next = 1'b0;
                    cnt_next   = tx_pkt_cnt + 32'd1;
                    if (MIN_GAP_CYCLES == 0) begin
                        state_next = S_IDLE;
                    end else begin
                        gap_next   = GAP_LOAD;
                        state_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_next = gap_cnt - 16'd1;
                if (gap_cnt <= 16'd1) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, gap counter, packet counter and all bus outputs are registered;
    // reset truncates any packet in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= S_IDLE;
            gap_cnt              <= '0;
            tx_pkt_cnt           <= '0;
            arp_tx.data          <= '0;
            arp_tx.empty         <= '0;
            arp_tx.startofpacket <= 1'b0;
            arp_tx.endofpacket   <= 1'b0;
            arp_tx.valid         <= 1'b0;
        end else begin
            state                <= state_next;
            gap_cnt              <= gap_next;
            tx_pkt_cnt           <= cnt_next;
            arp_tx.data          <= data_next;
            arp_tx.empty         <= empty_next;
            arp_tx.startofpacket <= sop_next;
            arp_tx.endofpacket   <= eop_next;
            arp_tx.valid         <= valid_next;
        end
    end

endmodule

// File: tb/tb_micro_udp_engine_arp_tx.sv
// -----------------------------------------------------------------------------
// tb_micro_udp_engine_arp_tx
// Self-checking bench for the ARP transmitter. One instance uses the default
// 16-cycle gap, a second one has no gap. Expected beats come from a byte-level
// model of the ARP layout.
// -----------------------------------------------------------------------------
module tb_micro_udp_engine_arp_tx;

    localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] MY_IP  = 32'hC0_A8_00_01;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // main instance, default gap
    logic        req_valid;
    logic        req_is_reply;
    logic [47:0] req_mac;
    logic [31:0] req_ip;
    wire         req_ready;
    wire  [31:0] pkt_cnt;
    micro_udp_engine_arp_tx_if tx_bus ();

    micro_udp_engine_arp_tx dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .arp_req_valid      (req_valid),
        .arp_req_ready      (req_ready),
        .arp_req_is_reply   (req_is_reply),
        .arp_req_target_mac (req_mac),
        .arp_req_target_ip  (req_ip),
        .arp_tx             (tx_bus),
        .tx_pkt_cnt         (pkt_cnt)
    );

    // second instance, no gap
    logic        req0_valid;
    logic        req0_is_reply;
    logic [47:0] req0_mac;
    logic [31:0] req0_ip;
    wire         req0_ready;
    wire  [31:0] pkt0_cnt;
    micro_udp_engine_arp_tx_if tx0_bus ();

    micro_udp_engine_arp_tx #(.MIN_GAP_CYCLES(0)) dut_nogap (
        .clk                (clk),
        .reset_n            (reset_n),
        .arp_req_valid      (req0_valid),
        .arp_req_ready      (req0_ready),
        .arp_req_is_reply   (req0_is_reply),
        .arp_req_target_mac (req0_mac),
        .arp_req_target_ip  (req0_ip),
        .arp_tx             (tx0_bus),
        .tx_pkt_cnt         (pkt0_cnt)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          beats = 0;
    int unsigned exp_cnt = 0;

    always @(posedge clk) cyc++;

    // beats transferred on the main instance
    always @(posedge clk) begin
        if (reset_n && tx_bus.valid && tx_bus.ready) beats++;
    end

    // byte-by-byte ARP body, first byte ends up in [255:248]
    function automatic logic [255:0] model_beat0(input bit is_reply,
                                                 input logic [47:0] mac,
                                                 input logic [31:0] ip);
        byte unsigned b[32];
        logic [47:0]  sha;
        logic [31:0]  spa;
        logic [255:0] r;
        sha = MY_MAC;
        spa = MY_IP;
        r   = '0;
        foreach (b[i]) b[i] = 8'h00;
        b[1] = 8'h01;
        b[2] = 8'h08;
        b[4] = 8'd6;
        b[5] = 8'd4;
        b[7] = is_reply ? 8'd2 : 8'd1;
        for (int i = 0; i < 6; i++) begin
            b[8 + i]  = sha[47 - 8*i -: 8];
            b[18 + i] = is_reply ? mac[47 - 8*i -: 8] : 8'h00;
        end
        for (int i = 0; i < 4; i++) begin
            b[14 + i] = spa[31 - 8*i -: 8];
            b[24 + i] = ip[31 - 8*i -: 8];
        end
        for (int i = 0; i < 32; i++) r[255 - 8*i -: 8] = b[i];
        return r;
    endfunction

    // Offer one descriptor to the main instance and follow its packet through,
    // with bp0/bp1 cycles of backpressure on beat 0 / beat 1.
    task automatic send_packet(input bit is_reply, input logic [47:0] mac,
                               input logic [31:0] ip, input int bp0, input int bp1,
                               output int acc_edge, output int eop_edge);
        logic [255:0] exp0;
        int           wait_n;
        int           beats_at;
        exp0         = model_beat0(is_reply, mac, ip);
        req_valid    = 1'b1;
        req_is_reply = is_reply;
        req_mac      = mac;
        req_ip       = ip;
        wait_n       = 0;
        eop_edge     = -1;
        while (!req_ready && wait_n < 100) begin
            @(posedge clk); #1;
            wait_n++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL accept_timeout req_ready=%0b required 1", req_ready);
        end
        @(posedge clk);
        acc_edge = cyc;
        #1;
        // scramble the inputs: the packet must use the latched descriptor
        req_valid    = 1'b0;
        req_is_reply = 1'($urandom);
        req_mac      = {16'($urandom), $urandom};
        req_ip       = $urandom;
        beats_at     = beats;
        for (int k = 0; k <= bp0; k++) begin
            tx_bus.ready = (k == bp0);
            total++;
            if (tx_bus.valid !== 1'b1 || tx_bus.startofpacket !== 1'b1 ||
                tx_bus.endofpacket !== 1'b0 || tx_bus.empty !== 5'd0 ||
                tx_bus.data !== exp0 || req_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL beat0 v=%0b sop=%0b eop=%0b empty=%0d rdy=%0b data=%h required v=1 sop=1 eop=0 empty=0 rdy=0 data=%h",
                         tx_bus.valid, tx_bus.startofpacket, tx_bus.endofpacket,
                         tx_bus.empty, req_ready, tx_bus.data, exp0);
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k <= bp1; k++) begin
            tx_bus.ready = (k == bp1);
            total++;
            if (tx_bus.valid !== 1'b1 || tx_bus.startofpacket !== 1'b0 ||
                tx_bus.endofpacket !== 1'b1 || tx_bus.empty !== 5'd18 ||
                tx_bus.data !== 256'h0 || req_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL beat1 v=%0b sop=%0b eop=%0b empty=%0d rdy=%0b data=%h required v=1 sop=0 eop=1 empty=18 rdy=0 data=0",
                         tx_bus.valid, tx_bus.startofpacket, tx_bus.endofpacket,
                         tx_bus.empty, req_ready, tx_bus.data);
            end
            @(posedge clk);
            if (k == bp1) eop_edge = cyc;
            #1;
        end
        exp_cnt++;
        total++;
        if (tx_bus.valid !== 1'b0 || tx_bus.endofpacket !== 1'b0 ||
            pkt_cnt !== 32'(exp_cnt) || beats - beats_at != 2) begin
            bad++;
            $display("[TB] FAIL pkt_end v=%0b eop=%0b cnt=%0d beats=%0d required v=0 eop=0 cnt=%0d beats=2",
                     tx_bus.valid, tx_bus.endofpacket, pkt_cnt, beats - beats_at, 32'(exp_cnt));
        end
        tx_bus.ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        req_valid     = 1'b0;
        req_is_reply  = 1'b0;
        req_mac       = '0;
        req_ip        = '0;
        req0_valid    = 1'b0;
        req0_is_reply = 1'b0;
        req0_mac      = '0;
        req0_ip       = '0;
        tx_bus.ready  = 1'b1;
        tx0_bus.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (tx_bus.valid !== 1'b0 || tx_bus.startofpacket !== 1'b0 ||
            tx_bus.endofpacket !== 1'b0 || tx_bus.empty !== 5'd0 ||
            tx_bus.data !== 256'h0 || pkt_cnt !== 32'd0 || req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset v=%0b sop=%0b eop=%0b empty=%0d cnt=%0d rdy=%0b required all 0, rdy=1",
                     tx_bus.valid, tx_bus.startofpacket, tx_bus.endofpacket,
                     tx_bus.empty, pkt_cnt, req_ready);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reply_basic();
        int a, e;
        send_packet(1'b1, 48'h02_00_00_00_00_AA, 32'hC0_A8_00_02, 0, 0, a, e);
        total++;
        if (e - a != 2) begin
            bad++;
            $display("[TB] FAIL reply_latency eop_edge-acc_edge=%0d required 2", e - a);
        end
    endtask

    task automatic test_request_broadcast();
        int a, e;
        send_packet(1'b0, 48'hFF_FF_FF_FF_FF_FF, 32'hC0_A8_00_07, 0, 0, a, e);
    endtask

    task automatic test_backpressure();
        int a, e;
        send_packet(1'b1, 48'h12_34_56_78_9A_BC, 32'h0A_00_00_05, 5, 3, a, e);
        total++;
        if (e - a != 10) begin
            bad++;
            $display("[TB] FAIL bp_duration eop_edge-acc_edge=%0d required 10", e - a);
        end
    endtask

    task automatic test_random();
        int a, e;
        for (int n = 0; n < 6; n++) begin
            send_packet(1'($urandom), {16'($urandom), $urandom}, $urandom,
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), a, e);
        end
    endtask

    task automatic test_back_to_back();
        int a1, e1, a2, e2;
        send_packet(1'b1, 48'h02_00_00_00_00_BB, 32'hC0_A8_00_03, 0, 0, a1, e1);
        send_packet(1'b0, 48'h02_00_00_00_00_CC, 32'hC0_A8_00_04, 0, 0, a2, e2);
        total++;
        if (a2 - e1 != 17) begin
            bad++;
            $display("[TB] FAIL gap16_accept accepted %0d cycles after EOP, required 17", a2 - e1);
        end
    endtask

    task automatic test_gap_zero();
        int           a1, e1, a2;
        logic [255:0] exp1, exp2;
        exp1 = model_beat0(1'b1, 48'h0A_0B_0C_0D_0E_0F, 32'h01_02_03_04);
        exp2 = model_beat0(1'b0, 48'h11_22_33_44_55_66, 32'h05_06_07_08);
        @(posedge clk); #1;
        req0_valid    = 1'b1;
        req0_is_reply = 1'b1;
        req0_mac      = 48'h0A_0B_0C_0D_0E_0F;
        req0_ip       = 32'h01_02_03_04;
        @(posedge clk);
        a1 = cyc;
        #1;
        req0_is_reply = 1'b0;
        req0_mac      = 48'h11_22_33_44_55_66;
        req0_ip       = 32'h05_06_07_08;
        total++;
        if (tx0_bus.valid !== 1'b1 || tx0_bus.startofpacket !== 1'b1 || tx0_bus.data !== exp1) begin
            bad++;
            $display("[TB] FAIL gap0_beat0 v=%0b sop=%0b data=%h required v=1 sop=1 data=%h",
                     tx0_bus.valid, tx0_bus.startofpacket, tx0_bus.data, exp1);
        end
        @(posedge clk); #1;
        total++;
        if (tx0_bus.endofpacket !== 1'b1 || tx0_bus.empty !== 5'd18 || req0_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL gap0_beat1 eop=%0b empty=%0d rdy=%0b required eop=1 empty=18 rdy=0",
                     tx0_bus.endofpacket, tx0_bus.empty, req0_ready);
        end
        @(posedge clk);
        e1 = cyc;
        #1;
        total++;
        if (req0_ready !== 1'b1 || tx0_bus.valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL gap0_idle rdy=%0b v=%0b required rdy=1 v=0", req0_ready, tx0_bus.valid);
        end
        @(posedge clk);
        a2 = cyc;
        #1;
        req0_valid = 1'b0;
        total++;
        if (a2 - e1 != 1 || tx0_bus.valid !== 1'b1 || tx0_bus.data !== exp2 ||
            pkt0_cnt !== 32'd1 || a1 <= 0) begin
            bad++;
            $display("[TB] FAIL gap0_second dist=%0d v=%0b cnt=%0d data=%h required dist=1 v=1 cnt=1 data=%h",
                     a2 - e1, tx0_bus.valid, pkt0_cnt, tx0_bus.data, exp2);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_packet();
        int a, e, wait_n;
        req_valid    = 1'b1;
        req_is_reply = 1'b1;
        req_mac      = 48'h02_00_00_00_00_DD;
        req_ip       = 32'hC0_A8_00_09;
        wait_n       = 0;
        while (!req_ready && wait_n < 100) begin
            @(posedge clk); #1;
            wait_n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        tx_bus.ready = 1'b0;
        total++;
        if (tx_bus.endofpacket !== 1'b1 || tx_bus.valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_pre eop=%0b v=%0b required eop=1 v=1", tx_bus.endofpacket, tx_bus.valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        exp_cnt = 0;
        total++;
        if (tx_bus.valid !== 1'b0 || tx_bus.endofpacket !== 1'b0 || pkt_cnt !== 32'd0) begin
            bad++;
            $display("[TB] FAIL rst_mid v=%0b eop=%0b cnt=%0d required 0 0 0",
                     tx_bus.valid, tx_bus.endofpacket, pkt_cnt);
        end
        tx_bus.ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        send_packet(1'b0, 48'h02_00_00_00_00_EE, 32'hC0_A8_00_0A, 1, 0, a, e);
    endtask

    task automatic test_counter_wrap();
        int a, e;
        force dut.tx_pkt_cnt = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.tx_pkt_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        send_packet(1'b1, 48'h02_00_00_00_00_FE, 32'hC0_A8_00_FE, 0, 0, a, e);
    endtask

    initial begin
        test_reset();
        test_reply_basic();
        test_request_broadcast();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_gap_zero();
        test_reset_mid_packet();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
